// File: rtl/des_pkg.sv
// DES tables and bit-permutation helpers shared by the key-mix stage.
// DES bit n (1-based, MSB first) of a W-bit vector lives at index W-n.
package des_pkg;

  typedef enum logic {IDLE, ACTIVE} km_state_t;

  localparam int E_TABLE [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int PC1_TABLE [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_TABLE [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  // Index 0 is encrypt round 1.
  localparam logic [1:0] SHIFTS [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  function automatic logic [47:0] expand(input logic [31:0] r);
    logic [47:0] res;
    res = '0;
    for (int i = 0; i < 48; i++) res[6'(47 - i)] = r[5'(32 - E_TABLE[i])];
    return res;
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] res;
    res = '0;
    for (int i = 0; i < 56; i++) res[6'(55 - i)] = key[6'(64 - PC1_TABLE[i])];
    return res;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] res;
    res = '0;
    for (int i = 0; i < 48; i++) res[6'(47 - i)] = cd[6'(56 - PC2_TABLE[i])];
    return res;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

endpackage

// File: rtl/des_subkey_gen.sv
// DES key schedule: C/D halves, round counter, per-round rotation and PC-2.
// Encrypt walks K1..K16, decrypt walks K16..K1; 16 advances return C/D to the load value.
module des_subkey_gen
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] key,
  input  logic        decrypt,
  input  logic        advance,
  output logic [47:0] subkey,
  output logic [3:0]  rnd
);

  logic [27:0] c_q, d_q;
  logic        dec_q;
  logic [55:0] cd_pc1;
  logic [1:0]  amt;

  // Shift that takes the schedule from round rnd to the next round in walk order.
  always_comb begin
    cd_pc1 = pc1(key);
    amt    = dec_q ? SHIFTS[4'd15 - rnd] : SHIFTS[rnd + 4'd1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q   <= '0;
      d_q   <= '0;
      rnd   <= '0;
      dec_q <= 1'b0;
    end else if (load) begin
      dec_q <= decrypt;
      rnd   <= '0;
      c_q   <= decrypt ? cd_pc1[55:28] : rotl28(cd_pc1[55:28], 2'd1);
      d_q   <= decrypt ? cd_pc1[27:0]  : rotl28(cd_pc1[27:0], 2'd1);
    end else if (advance) begin
      rnd <= rnd + 4'd1;
      c_q <= dec_q ? rotr28(c_q, amt) : rotl28(c_q, amt);
      d_q <= dec_q ? rotr28(d_q, amt) : rotl28(d_q, amt);
    end
  end

  assign subkey = pc2({c_q, d_q});

endmodule

// File: rtl/des_key_mix.sv
// Registers E(R)^K for the eight DES S-boxes, one Feistel round per input handshake.
// Define DES_KEY_PARITY_EN to reject key loads that are not odd parity per byte.
module des_key_mix
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_key,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic [31:0] r_in,
  input  logic        r_valid,
  output logic        r_ready,
  output logic [47:0] sbox_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  round_idx,
  output logic        last_round,
  output logic        key_err
);

  // state  | meaning
  // IDLE   | no key loaded since reset; r_in refused
  // ACTIVE | key loaded; each accepted r_in produces one round of sbox_in

  km_state_t   state, state_next;
  logic        parity_ok, load_ok, accept;
  logic [47:0] subkey;
  logic [3:0]  rnd;

`ifdef DES_KEY_PARITY_EN
  assign parity_ok = &{^key_in[63:56], ^key_in[55:48], ^key_in[47:40], ^key_in[39:32],
                       ^key_in[31:24], ^key_in[23:16], ^key_in[15:8],  ^key_in[7:0]};

  always_ff @(posedge clk) begin
    if (rst)           key_err <= 1'b0;
    else if (load_key) key_err <= !parity_ok;
  end
`else
  assign parity_ok = 1'b1;
  assign key_err   = 1'b0;
`endif

  always_comb begin
    state_next = state;
    load_ok    = load_key && parity_ok;
    r_ready    = (state == ACTIVE) && !load_key && (!out_valid || out_ready);
    accept     = r_valid && r_ready;
    if (load_ok) state_next = ACTIVE;
  end

  des_subkey_gen u_subkey_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (load_ok),
    .key     (key_in),
    .decrypt (decrypt),
    .advance (accept),
    .subkey  (subkey),
    .rnd     (rnd)
  );

  // A reload discards any pending output; r_ready is low then, so no accept can collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      sbox_in   <= '0;
      round_idx <= '0;
    end else begin
      state <= state_next;
      if (load_ok) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        sbox_in   <= expand(r_in) ^ subkey;
        round_idx <= rnd;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign last_round = out_valid && (round_idx == 4'd15);

endmodule
